core_mem: RTL and testbench
===========================

# core_mem

Memory-access pipeline stage between `core_ex` and write-back. It consumes `EX_MEM_t` and performs loads and stores over a single-outstanding 64-bit data-bus handshake. Every other instruction passes through unchanged. It produces `MEM_WB_t` and stalls upstream while a bus transaction is in flight.

## Interface
- No parameters; bus width is fixed at 64 bits.
- `i_clk`  in  1  clock
- `i_reset`  in  1  reset, synchronous, active-high
- `i_EX_MEM`  in  `EX_MEM_t`  fields: `valid`, `PC`, `funct3`, `data` (store data / ALU result), `addr`, `rd`, `we`, `ld`, `st`, `csr`, `csr_data`, `csr_st`
- `o_MEM_WB`  out  `MEM_WB_t`  fields: `valid`, `PC`, `data`, `rd`, `we`, `csr`, `csr_data`, `csr_st`, `fault`, `fault_cause[1:0]`
- `i_stall`  in  1  downstream stall; hold `o_MEM_WB`
- `i_flush`  in  1  squash the current contents
- `o_busy`  out  1  stall request to EX/ID/IF
- `o_dbus_req`  out  1  request valid
- `o_dbus_we`  out  1  1 = write
- `o_dbus_addr`  out  64  doubleword-aligned address, `{addr[63:3],3'b0}`
- `o_dbus_wdata`  out  64  lane-shifted store data
- `o_dbus_wstrb`  out  8  byte enables
- `i_dbus_ack`  in  1  completes the request this cycle
- `i_dbus_err`  in  1  valid only with ack; access fault
- `i_dbus_rdata`  in  64  valid only with ack

## Operation
- Memory op means `i_EX_MEM.valid && (ld || st)`. Its size comes from `funct3`: B=000, H=001, W=010, D=011, BU=100, HU=101, WU=110.
- Lane `a = addr[2:0]`.
  - Store strobes: B `1<<a`, H `3<<a`, W `8'h0F<<a`, D `8'hFF`.
  - `wdata = data << (8*a)`.
- Load data is `rdata >> (8*a)`, truncated to size, then sign-extended (000–011) or zero-extended (1xx) to 64 bits.
- Misaligned means H with `a[0]`, W with `a[1:0]!=0`, or D with `a!=0`. Such an op issues no bus request. It produces `MEM_WB` with `valid=1`, `fault=1`, `fault_cause=2'b01`, `we=0`, in one cycle like a non-memory op.
- Bus error (`ack && err`): `fault=1`, `fault_cause=2'b10`, `we=0`, `data=0`.
- Non-memory op: one-cycle pass-through of `data`, `rd`, `we`, `csr*`, `PC`, with `fault=0`.
- Store result: `MEM_WB.valid=1`, `we=0`.
- FSM states:
  - IDLE: an aligned memory op with `!i_stall && !i_flush` captures addr, wstrb, wdata, funct3 and metadata into request registers, then goes to BUS.
  - BUS: `o_dbus_req=1` with all bus outputs stable.
    - `ack && !i_stall`: register `MEM_WB`, go to IDLE.
    - `ack && i_stall`: latch the result into a skid register, go to HOLD.
  - HOLD: on `!i_stall`, move the skid register to `MEM_WB`, go to IDLE.
  - DRAIN: entered from BUS on `i_flush`. Keep `req` asserted until ack, discard the result, go to IDLE. An issued store is not cancelled.
- `o_busy` is combinational and equals any of:
  - (IDLE && aligned memory op present)
  - (BUS && !i_dbus_ack)
  - HOLD
  - DRAIN
- `i_flush` in IDLE or HOLD: `MEM_WB` cleared to `valid=0`; HOLD returns to IDLE.
- `i_flush` simultaneous with ack in BUS: the result is discarded, state goes to IDLE.
- Reset and flush take priority over everything else. Reset wins over flush.

## Timing
- Reset (any state, including mid-transaction): state IDLE, every `o_MEM_WB` field 0, `o_dbus_req=0`, `o_dbus_we=0`, `o_dbus_addr/wdata/wstrb=0`, `o_busy=0` on the following cycle. The bus slave is reset by the same `i_reset`.
- Non-memory or misaligned op: `MEM_WB` valid one edge after arrival.
- Memory op: arrival cycle N (IDLE, `o_busy=1`), `req` from cycle N+1. Ack in cycle M gives `MEM_WB` valid after edge M (minimum latency 2 cycles with ack in N+1).
- `o_busy` drops in the ack cycle, so EX advances on the same edge.
- When `i_stall=1`, `o_MEM_WB` holds its value. `MEM_WB.valid` is never set from a stalled input.
- At most one transaction outstanding. `req` never drops before ack.

## Structure
- `MEM_WB_t` and the fault-cause constants (`FC_NONE=0`, `FC_MISALIGN=1`, `FC_ACCESS=2`) are added to `WivDefines`. Load/store size encodings reuse the existing `funct3` constants there.
- Sub-module `core_mem_align` is combinational. It holds the misalignment check, strobe and wdata generation, and load extraction/extension, shared by the issue and response paths.
- The FSM and the request, skid and output registers live in `core_mem`.

## Test plan
- ALU pass-through, `data=64'h1234`, `rd=5`, `we=1`: `MEM_WB` reflects it after 1 cycle, `fault=0`, `o_busy` stays 0.
- LB with `addr=0x1003`, rdata `0x00000000_80000000`, ack on the first req cycle: `dbus_addr=0x1000`, `MEM_WB.data=0xFFFF_FFFF_FFFF_FF80` two cycles after arrival. Repeat as LBU: expect `0x80`.
- SH with `addr=0x2006`, `data=0xABCD`: `wstrb=8'hC0`, `wdata=0xABCD_0000_0000_0000`, `we=1`. Ack delayed 3 cycles: `o_busy` high through the last non-ack cycle, `MEM_WB.we=0`.
- LW with `addr=0x3002`: no req, `MEM_WB.fault=1`, `fault_cause=1` after 1 cycle. LD with ack+err: `fault_cause=2`, `we=0`.
- `i_flush` during BUS: `req` held until ack, then `MEM_WB.valid=0`. `i_stall` high at ack: HOLD, then result delivered on the first unstalled edge.
- `i_reset` asserted in BUS: next cycle `req=0`, state IDLE, all outputs 0.

Source files
------------

// File: rtl/core_mem_pkg.sv
// Shared types and constants for the core_mem memory-access stage.
package core_mem_pkg;

  // Load/store size encodings carried in funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Fault causes reported to write-back
  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISALIGN = 2'd1;
  localparam logic [1:0] FC_ACCESS   = 2'd2;

  typedef struct packed {
    logic        valid;
    logic [63:0] PC;
    logic [2:0]  funct3;
    logic [63:0] data;
    logic [63:0] addr;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic        st;
    logic [11:0] csr;
    logic [63:0] csr_data;
    logic        csr_st;
  } EX_MEM_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] PC;
    logic [63:0] data;
    logic [4:0]  rd;
    logic        we;
    logic [11:0] csr;
    logic [63:0] csr_data;
    logic        csr_st;
    logic        fault;
    logic [1:0]  fault_cause;
  } MEM_WB_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } mem_state_e;

endpackage

// File: rtl/core_mem_if.sv
// 64-bit single-outstanding data-bus handshake between core_mem and memory.
interface core_mem_if;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        ack;
  logic        err;
  logic [63:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  ack, err, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output ack, err, rdata
  );
endinterface

// File: rtl/core_mem_align.sv
// Byte-lane handling for core_mem: misalignment check and store lane
// placement on the issue side, load extraction and extension on the
// response side.
module core_mem_align
  import core_mem_pkg::*;
(
  input  logic [2:0]  iss_funct3,
  input  logic [2:0]  iss_lane,
  input  logic [63:0] iss_data,
  output logic        iss_misalign,
  output logic [7:0]  iss_wstrb,
  output logic [63:0] iss_wdata,
  input  logic [2:0]  rsp_funct3,
  input  logic [2:0]  rsp_lane,
  input  logic [63:0] rsp_rdata,
  output logic [63:0] rsp_data
);

  logic [63:0] rsp_shift_s;

  // Issue side: natural-alignment check, byte strobes and lane-shifted store data
  always_comb begin
    iss_misalign = 1'b0;
    iss_wstrb    = 8'h00;
    iss_wdata    = iss_data << {iss_lane, 3'b000};
    case (iss_funct3)
      F3_B, F3_BU: begin
        iss_misalign = 1'b0;
        iss_wstrb    = 8'h01 << iss_lane;
      end
      F3_H, F3_HU: begin
        iss_misalign = iss_lane[0];
        iss_wstrb    = 8'h03 << iss_lane;
      end
      F3_W, F3_WU: begin
        iss_misalign = (iss_lane[1:0] != 2'b00);
        iss_wstrb    = 8'h0F << iss_lane;
      end
      F3_D: begin
        iss_misalign = (iss_lane != 3'b000);
        iss_wstrb    = 8'hFF;
      end
      default: begin
        iss_misalign = 1'b0;
        iss_wstrb    = 8'h00;
      end
    endcase
  end

  // Response side: move the addressed bytes to bit 0, then sign/zero extend
  always_comb begin
    rsp_shift_s = rsp_rdata >> {rsp_lane, 3'b000};
    rsp_data    = rsp_shift_s;
    case (rsp_funct3)
      F3_B:    rsp_data = {{56{rsp_shift_s[7]}}, rsp_shift_s[7:0]};
      F3_H:    rsp_data = {{48{rsp_shift_s[15]}}, rsp_shift_s[15:0]};
      F3_W:    rsp_data = {{32{rsp_shift_s[31]}}, rsp_shift_s[31:0]};
      F3_D:    rsp_data = rsp_shift_s;
      F3_BU:   rsp_data = {56'd0, rsp_shift_s[7:0]};
      F3_HU:   rsp_data = {48'd0, rsp_shift_s[15:0]};
      F3_WU:   rsp_data = {32'd0, rsp_shift_s[31:0]};
      default: rsp_data = rsp_shift_s;
    endcase
  end

endmodule

// File: rtl/core_mem.sv
// Memory-access pipeline stage: passes non-memory ops through in one cycle,
// runs loads/stores over a single-outstanding data bus and stalls upstream
// while a transaction is in flight.
module core_mem
  import core_mem_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  EX_MEM_t           i_EX_MEM,
  output MEM_WB_t           o_MEM_WB,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic              o_busy,
  core_mem_if.master        dbus
);

  mem_state_e  state_r, state_s;
  MEM_WB_t     mem_wb_r, mem_wb_s;
  MEM_WB_t     skid_r;
  MEM_WB_t     req_meta_r;
  MEM_WB_t     pass_res_s, bus_res_s;
  logic [63:0] req_addr_r, req_wdata_r;
  logic [7:0]  req_wstrb_r;
  logic        req_we_r, req_ld_r;
  logic [2:0]  req_funct3_r, req_lane_r;
  logic        mem_op_s, misalign_s, capture_s, skid_load_s, busy_s;
  logic [7:0]  iss_wstrb_s;
  logic [63:0] iss_wdata_s, ld_data_s;

  assign mem_op_s = i_EX_MEM.valid && (i_EX_MEM.ld || i_EX_MEM.st);

  core_mem_align u_align (
    .iss_funct3   (i_EX_MEM.funct3),
    .iss_lane     (i_EX_MEM.addr[2:0]),
    .iss_data     (i_EX_MEM.data),
    .iss_misalign (misalign_s),
    .iss_wstrb    (iss_wstrb_s),
    .iss_wdata    (iss_wdata_s),
    .rsp_funct3   (req_funct3_r),
    .rsp_lane     (req_lane_r),
    .rsp_rdata    (dbus.rdata),
    .rsp_data     (ld_data_s)
  );

  // One-cycle result for non-memory ops and misaligned memory ops
  always_comb begin
    pass_res_s = '0;
    if (i_EX_MEM.valid) begin
      pass_res_s.valid    = 1'b1;
      pass_res_s.PC       = i_EX_MEM.PC;
      pass_res_s.rd       = i_EX_MEM.rd;
      pass_res_s.csr      = i_EX_MEM.csr;
      pass_res_s.csr_data = i_EX_MEM.csr_data;
      pass_res_s.csr_st   = i_EX_MEM.csr_st;
      if (mem_op_s) begin
        pass_res_s.fault       = 1'b1;
        pass_res_s.fault_cause = FC_MISALIGN;
        pass_res_s.we          = 1'b0;
        pass_res_s.data        = 64'd0;
      end else begin
        pass_res_s.fault       = 1'b0;
        pass_res_s.fault_cause = FC_NONE;
        pass_res_s.we          = i_EX_MEM.we;
        pass_res_s.data        = i_EX_MEM.data;
      end
    end else begin
      pass_res_s = '0;
    end
  end

  // Result of the outstanding bus transaction, valid in the ack cycle
  always_comb begin
    bus_res_s = req_meta_r;
    if (dbus.err) begin
      bus_res_s.fault       = 1'b1;
      bus_res_s.fault_cause = FC_ACCESS;
      bus_res_s.we          = 1'b0;
      bus_res_s.data        = 64'd0;
    end else if (req_ld_r) begin
      bus_res_s.data = ld_data_s;
    end else begin
      bus_res_s.we   = 1'b0;
      bus_res_s.data = 64'd0;
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, next output value and the busy/stall request
  always_comb begin
    state_s     = state_r;
    mem_wb_s    = mem_wb_r;
    capture_s   = 1'b0;
    skid_load_s = 1'b0;
    busy_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s = mem_op_s && !misalign_s;
        if (i_flush) begin
          mem_wb_s = '0;
        end else if (i_stall) begin
          mem_wb_s = mem_wb_r;
        end else if (mem_op_s && !misalign_s) begin
          capture_s = 1'b1;
          mem_wb_s  = '0;
          state_s   = ST_BUS;
        end else begin
          mem_wb_s = pass_res_s;
        end
      end
      ST_BUS: begin
        busy_s = !dbus.ack;
        if (i_flush) begin
          mem_wb_s = '0;
          state_s  = dbus.ack ? ST_IDLE : ST_DRAIN;
        end else if (dbus.ack && i_stall) begin
          skid_load_s = 1'b1;
          state_s     = ST_HOLD;
        end else if (dbus.ack) begin
          mem_wb_s = bus_res_s;
          state_s  = ST_IDLE;
        end else if (i_stall) begin
          mem_wb_s = mem_wb_r;
        end else begin
          mem_wb_s = '0;
        end
      end
      ST_HOLD: begin
        busy_s = 1'b1;
        if (i_flush) begin
          mem_wb_s = '0;
          state_s  = ST_IDLE;
        end else if (!i_stall) begin
          mem_wb_s = skid_r;
          state_s  = ST_IDLE;
        end else begin
          mem_wb_s = mem_wb_r;
        end
      end
      ST_DRAIN: begin
        // An issued request cannot be withdrawn; wait for ack and drop it
        busy_s  = 1'b1;
        state_s = dbus.ack ? ST_IDLE : ST_DRAIN;
        if (i_flush || !i_stall) begin
          mem_wb_s = '0;
        end else begin
          mem_wb_s = mem_wb_r;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        mem_wb_s = '0;
      end
    endcase
  end

  // Request registers: captured once per transaction so the bus stays stable
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      req_addr_r   <= 64'd0;
      req_wdata_r  <= 64'd0;
      req_wstrb_r  <= 8'h00;
      req_we_r     <= 1'b0;
      req_ld_r     <= 1'b0;
      req_funct3_r <= 3'b000;
      req_lane_r   <= 3'b000;
      req_meta_r   <= '0;
    end else if (capture_s) begin
      req_addr_r          <= {i_EX_MEM.addr[63:3], 3'b000};
      req_we_r            <= i_EX_MEM.st && !i_EX_MEM.ld;
      req_ld_r            <= i_EX_MEM.ld;
      req_wdata_r         <= (i_EX_MEM.st && !i_EX_MEM.ld) ? iss_wdata_s : 64'd0;
      req_wstrb_r         <= (i_EX_MEM.st && !i_EX_MEM.ld) ? iss_wstrb_s : 8'h00;
      req_funct3_r        <= i_EX_MEM.funct3;
      req_lane_r          <= i_EX_MEM.addr[2:0];
      req_meta_r          <= '0;
      req_meta_r.valid    <= 1'b1;
      req_meta_r.PC       <= i_EX_MEM.PC;
      req_meta_r.rd       <= i_EX_MEM.rd;
      req_meta_r.we       <= i_EX_MEM.we;
      req_meta_r.csr      <= i_EX_MEM.csr;
      req_meta_r.csr_data <= i_EX_MEM.csr_data;
      req_meta_r.csr_st   <= i_EX_MEM.csr_st;
    end else begin
      req_addr_r <= req_addr_r;
    end
  end

  // Skid register holds a response that arrived while write-back was stalled
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      skid_r <= '0;
    end else if (skid_load_s) begin
      skid_r <= bus_res_s;
    end else begin
      skid_r <= skid_r;
    end
  end

  // Output register toward write-back
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mem_wb_r <= '0;
    end else begin
      mem_wb_r <= mem_wb_s;
    end
  end

  assign o_MEM_WB   = mem_wb_r;
  assign o_busy     = busy_s;
  assign dbus.req   = (state_r == ST_BUS) || (state_r == ST_DRAIN);
  assign dbus.we    = req_we_r;
  assign dbus.addr  = req_addr_r;
  assign dbus.wdata = req_wdata_r;
  assign dbus.wstrb = req_wstrb_r;

endmodule

// File: tb/tb_core_mem.sv
// Self-checking bench for core_mem: directed ops with a scoreboard of
// expected write-back results, compared whenever a fresh result appears.
module tb_core_mem;
  import core_mem_pkg::*;

  typedef struct {
    MEM_WB_t wb;
    logic    chk_data;
  } sb_t;

  logic    i_clk = 1'b0;
  logic    i_reset, i_stall, i_flush, o_busy;
  EX_MEM_t ex_in;
  MEM_WB_t mem_wb;
  logic    stall_q = 1'b1;
  logic    rst_q = 1'b1;
  sb_t     sb_q[$];
  sb_t     sb_e;
  int      n_checks = 0;
  int      n_pass = 0;

  core_mem_if dbus_if ();

  core_mem dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_EX_MEM (ex_in),
    .o_MEM_WB (mem_wb),
    .i_stall  (i_stall),
    .i_flush  (i_flush),
    .o_busy   (o_busy),
    .dbus     (dbus_if)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic EX_MEM_t mk_ex(input logic [63:0] pc, input logic [2:0] f3, input logic [63:0] data,
                                    input logic [63:0] addr, input logic [4:0] rd, input logic we,
                                    input logic ld, input logic st);
    EX_MEM_t e;
    e = '0;
    e.valid = 1'b1; e.PC = pc; e.funct3 = f3; e.data = data; e.addr = addr;
    e.rd = rd; e.we = we; e.ld = ld; e.st = st;
    return e;
  endfunction

  function automatic MEM_WB_t mk_wb(input logic [63:0] pc, input logic [63:0] data, input logic [4:0] rd,
                                    input logic we, input logic fault, input logic [1:0] cause);
    MEM_WB_t w;
    w = '0;
    w.valid = 1'b1; w.PC = pc; w.data = data; w.rd = rd; w.we = we;
    w.fault = fault; w.fault_cause = cause;
    return w;
  endfunction

  // Track whether the last edge was stalled or in reset
  always @(posedge i_clk) begin
    stall_q <= i_stall;
    rst_q   <= i_reset;
  end

  // Scoreboard: a valid output after an unstalled edge is a new result
  always @(negedge i_clk) begin
    if (!rst_q && !stall_q && mem_wb.valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_result", 64'(mem_wb.PC), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        sb_e = sb_q.pop_front();
        check("wb_pc", mem_wb.PC, sb_e.wb.PC);
        check("wb_rd", 64'(mem_wb.rd), 64'(sb_e.wb.rd));
        check("wb_we", 64'(mem_wb.we), 64'(sb_e.wb.we));
        check("wb_fault", 64'(mem_wb.fault), 64'(sb_e.wb.fault));
        check("wb_cause", 64'(mem_wb.fault_cause), 64'(sb_e.wb.fault_cause));
        if (sb_e.chk_data) check("wb_data", mem_wb.data, sb_e.wb.data);
      end
    end
  end

  // One-cycle op (non-memory or misaligned): result after one edge, no bus request
  task automatic pass_op(input EX_MEM_t ex, input MEM_WB_t e_wb, input logic chk_data);
    sb_t s;
    s.wb = e_wb; s.chk_data = chk_data;
    ex_in = ex;
    sb_q.push_back(s);
    #1;
    check("pass_busy", 64'(o_busy), 64'd0);
    @(negedge i_clk);
    check("pass_valid", 64'(mem_wb.valid), 64'd1);
    check("pass_no_req", 64'(dbus_if.req), 64'd0);
    ex_in = '0;
  endtask

  // Memory op; mode 0 normal, 1 stall at ack (skid/HOLD), 2 flush in first bus cycle
  task automatic mem_op(input EX_MEM_t ex, input int dly, input logic err, input logic [63:0] rdat,
                        input logic [63:0] e_addr, input logic e_we, input logic chk_wr,
                        input logic [7:0] e_wstrb, input logic [63:0] e_wdata,
                        input MEM_WB_t e_wb, input logic chk_data, input int mode);
    sb_t s;
    s.wb = e_wb; s.chk_data = chk_data;
    ex_in = ex;
    if (mode != 2) sb_q.push_back(s);
    #1;
    check("busy_arrive", 64'(o_busy), 64'd1);
    @(negedge i_clk);
    for (int c = 0; c <= dly; c++) begin
      check("bus_req", 64'(dbus_if.req), 64'd1);
      check("bus_addr", dbus_if.addr, e_addr);
      check("bus_we", 64'(dbus_if.we), 64'(e_we));
      if (chk_wr) begin
        check("bus_wstrb", 64'(dbus_if.wstrb), 64'(e_wstrb));
        check("bus_wdata", dbus_if.wdata, e_wdata);
      end
      if (mode == 2 && c == 0) begin
        i_flush = 1'b1;
        ex_in   = '0;
      end
      if (c == dly) begin
        dbus_if.ack   = 1'b1;
        dbus_if.err   = err;
        dbus_if.rdata = rdat;
        if (mode == 1) i_stall = 1'b1;
        #1;
        check("busy_ack", 64'(o_busy), (mode == 2) ? 64'd1 : 64'd0);
      end else begin
        #1;
        check("busy_wait", 64'(o_busy), 64'd1);
      end
      @(negedge i_clk);
      i_flush       = 1'b0;
      dbus_if.ack   = 1'b0;
      dbus_if.err   = 1'b0;
      dbus_if.rdata = 64'd0;
    end
    ex_in = '0;
    #1;
    check("req_after_ack", 64'(dbus_if.req), 64'd0);
    if (mode == 1) begin
      check("hold_busy", 64'(o_busy), 64'd1);
      check("hold_valid", 64'(mem_wb.valid), 64'd0);
      @(negedge i_clk);
      check("hold_valid2", 64'(mem_wb.valid), 64'd0);
      i_stall = 1'b0;
      @(negedge i_clk);
      check("hold_release", 64'(mem_wb.valid), 64'd1);
    end else begin
      check("busy_after", 64'(o_busy), 64'd0);
      check("valid_after", 64'(mem_wb.valid), (mode == 0) ? 64'd1 : 64'd0);
    end
  endtask

  initial begin
    i_reset = 1'b1; i_stall = 1'b0; i_flush = 1'b0; ex_in = '0;
    dbus_if.ack = 1'b0; dbus_if.err = 1'b0; dbus_if.rdata = 64'd0;
    repeat (3) @(negedge i_clk);
    check("rst_mem_wb", 64'(|mem_wb), 64'd0);
    check("rst_req", 64'(dbus_if.req), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_addr", dbus_if.addr, 64'd0);
    i_reset = 1'b0;
    @(negedge i_clk);

    // ALU pass-through
    pass_op(mk_ex(64'h100, 3'b000, 64'h1234, 64'h0, 5'd5, 1'b1, 1'b0, 1'b0),
            mk_wb(64'h100, 64'h1234, 5'd5, 1'b1, 1'b0, FC_NONE), 1'b1);
    // LB / LBU at lane 3
    mem_op(mk_ex(64'h104, F3_B, 64'h0, 64'h1003, 5'd6, 1'b1, 1'b1, 1'b0), 0, 1'b0,
           64'h0000_0000_8000_0000, 64'h1000, 1'b0, 1'b0, 8'h00, 64'h0,
           mk_wb(64'h104, 64'hFFFF_FFFF_FFFF_FF80, 5'd6, 1'b1, 1'b0, FC_NONE), 1'b1, 0);
    mem_op(mk_ex(64'h108, F3_BU, 64'h0, 64'h1003, 5'd6, 1'b1, 1'b1, 1'b0), 0, 1'b0,
           64'h0000_0000_8000_0000, 64'h1000, 1'b0, 1'b0, 8'h00, 64'h0,
           mk_wb(64'h108, 64'h80, 5'd6, 1'b1, 1'b0, FC_NONE), 1'b1, 0);
    // SH at lane 6, ack after 3 waiting cycles
    mem_op(mk_ex(64'h10C, F3_H, 64'hABCD, 64'h2006, 5'd7, 1'b0, 1'b0, 1'b1), 3, 1'b0,
           64'h0, 64'h2000, 1'b1, 1'b1, 8'hC0, 64'hABCD_0000_0000_0000,
           mk_wb(64'h10C, 64'h0, 5'd7, 1'b0, 1'b0, FC_NONE), 1'b0, 0);
    // Misaligned LW
    pass_op(mk_ex(64'h110, F3_W, 64'h0, 64'h3002, 5'd8, 1'b1, 1'b1, 1'b0),
            mk_wb(64'h110, 64'h0, 5'd8, 1'b0, 1'b1, FC_MISALIGN), 1'b0);
    // LD with bus error
    mem_op(mk_ex(64'h114, F3_D, 64'h0, 64'h4000, 5'd9, 1'b1, 1'b1, 1'b0), 1, 1'b1,
           64'hDEAD_BEEF_DEAD_BEEF, 64'h4000, 1'b0, 1'b0, 8'h00, 64'h0,
           mk_wb(64'h114, 64'h0, 5'd9, 1'b0, 1'b1, FC_ACCESS), 1'b1, 0);
    // LD flushed while on the bus: result discarded
    mem_op(mk_ex(64'h118, F3_D, 64'h0, 64'h4008, 5'd10, 1'b1, 1'b1, 1'b0), 2, 1'b0,
           64'h1111_2222_3333_4444, 64'h4008, 1'b0, 1'b0, 8'h00, 64'h0,
           '0, 1'b0, 2);
    // LW with stall at ack
    mem_op(mk_ex(64'h11C, F3_W, 64'h0, 64'h5004, 5'd11, 1'b1, 1'b1, 1'b0), 1, 1'b0,
           64'h8765_4321_0000_0000, 64'h5000, 1'b0, 1'b0, 8'h00, 64'h0,
           mk_wb(64'h11C, 64'hFFFF_FFFF_8765_4321, 5'd11, 1'b1, 1'b0, FC_NONE), 1'b1, 1);
    // Flush in IDLE squashes an arriving op
    ex_in   = mk_ex(64'h120, 3'b000, 64'h77, 64'h0, 5'd3, 1'b1, 1'b0, 1'b0);
    i_flush = 1'b1;
    @(negedge i_clk);
    check("flush_idle_valid", 64'(mem_wb.valid), 64'd0);
    i_flush = 1'b0;
    ex_in   = '0;
    // SD full doubleword, LHU at lane 6
    mem_op(mk_ex(64'h124, F3_D, 64'h0123_4567_89AB_CDEF, 64'h6000, 5'd12, 1'b0, 1'b0, 1'b1), 0, 1'b0,
           64'h0, 64'h6000, 1'b1, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF,
           mk_wb(64'h124, 64'h0, 5'd12, 1'b0, 1'b0, FC_NONE), 1'b0, 0);
    mem_op(mk_ex(64'h128, F3_HU, 64'h0, 64'h6006, 5'd13, 1'b1, 1'b1, 1'b0), 0, 1'b0,
           64'hBEEF_0000_0000_0000, 64'h6000, 1'b0, 1'b0, 8'h00, 64'h0,
           mk_wb(64'h128, 64'hBEEF, 5'd13, 1'b1, 1'b0, FC_NONE), 1'b1, 0);

    // Reset in the middle of a store transaction
    ex_in = mk_ex(64'h12C, F3_D, 64'h55, 64'h7008, 5'd14, 1'b0, 1'b0, 1'b1);
    @(negedge i_clk);
    check("pre_rst_req", 64'(dbus_if.req), 64'd1);
    check("pre_rst_we", 64'(dbus_if.we), 64'd1);
    i_reset = 1'b1;
    ex_in   = '0;
    @(negedge i_clk);
    check("mid_rst_req", 64'(dbus_if.req), 64'd0);
    check("mid_rst_we", 64'(dbus_if.we), 64'd0);
    check("mid_rst_addr", dbus_if.addr, 64'd0);
    check("mid_rst_wdata", dbus_if.wdata, 64'd0);
    check("mid_rst_wstrb", 64'(dbus_if.wstrb), 64'd0);
    check("mid_rst_busy", 64'(o_busy), 64'd0);
    check("mid_rst_mem_wb", 64'(|mem_wb), 64'd0);
    i_reset = 1'b0;
    @(negedge i_clk);
    pass_op(mk_ex(64'h130, 3'b000, 64'h9999, 64'h0, 5'd15, 1'b1, 1'b0, 1'b0),
            mk_wb(64'h130, 64'h9999, 5'd15, 1'b1, 1'b0, FC_NONE), 1'b1);

    repeat (3) @(negedge i_clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
